// File: rtl/arb_types.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_grant_t : which requester last received the port
//   rr_pick     : round-robin choice between the fetch and data sides
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DRAIN_I = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Fetch wins when it is alone, or on a tie when data had the last grant.
  function automatic arb_grant_t rr_pick(input logic i_req,
                                         input logic d_req,
                                         input arb_grant_t last_grant);
    if (i_req && (!d_req || last_grant == GRANT_D)) begin
      return GRANT_I;
    end
    return GRANT_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction fetcher
// (read-only) and the load/store unit (read/write).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   fls                  pipeline flush, cancels fetch-side traffic only
//   i_read, i_address    fetch request (held until i_resp)
//   i_rdata, i_resp      fetch read data and one-cycle completion
//   d_read, d_write      LSU request (held until d_resp)
//   d_wmask, d_address, d_wdata   LSU request payload
//   d_rdata, d_resp      LSU read data and one-cycle completion
//   mem_read, mem_write, mem_wmask, mem_address, mem_wdata  registered port
//   mem_rdata, mem_resp  memory read data and one-cycle completion
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fls,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  arb_state_t              state_reg, state_next;
  arb_grant_t              last_grant_reg, last_grant_next;
  logic                    mem_read_reg, mem_read_next;
  logic                    mem_write_reg, mem_write_next;
  logic [MASK_WIDTH-1:0]   mem_wmask_reg, mem_wmask_next;
  logic [ADDR_WIDTH-1:0]   mem_address_reg, mem_address_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                    i_req;
  logic                    d_req;

  assign i_req = i_read & ~fls;
  assign d_req = d_read | d_write;

  // Read data is a plain pass-through; only the resp pulses are qualified.
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign mem_read    = mem_read_reg;
  assign mem_write   = mem_write_reg;
  assign mem_wmask   = mem_wmask_reg;
  assign mem_address = mem_address_reg;
  assign mem_wdata   = mem_wdata_reg;

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    mem_read_next    = mem_read_reg;
    mem_write_next   = mem_write_reg;
    mem_wmask_next   = mem_wmask_reg;
    mem_address_next = mem_address_reg;
    mem_wdata_next   = mem_wdata_reg;
    i_resp           = 1'b0;
    d_resp           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          if (rr_pick(i_req, d_req, last_grant_reg) == GRANT_I) begin
            state_next       = SERVE_I;
            last_grant_next  = GRANT_I;
            mem_read_next    = 1'b1;
            mem_write_next   = 1'b0;
            mem_wmask_next   = '0;
            mem_address_next = i_address;
            mem_wdata_next   = '0;
          end else begin
            state_next       = SERVE_D;
            last_grant_next  = GRANT_D;
            // A simultaneous read+write is illegal; the write takes priority.
            mem_read_next    = d_read & ~d_write;
            mem_write_next   = d_write;
            mem_wmask_next   = d_wmask;
            mem_address_next = d_address;
            mem_wdata_next   = d_wdata;
          end
        end
      end

      SERVE_I: begin
        // A flush in the completion cycle swallows the response.
        i_resp = mem_resp & ~fls & ~rst;
        if (mem_resp) begin
          state_next     = IDLE;
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
        end else if (fls) begin
          state_next = DRAIN_I;
        end
      end

      DRAIN_I: begin
        // The memory still owes a response for the cancelled fetch; keep the
        // request on the port and wait for it silently.
        if (mem_resp) begin
          state_next     = IDLE;
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
        end
      end

      SERVE_D: begin
        d_resp = mem_resp & ~rst;
        if (mem_resp) begin
          state_next     = IDLE;
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_grant_reg  <= GRANT_D;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_wmask_reg   <= '0;
      mem_address_reg <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      mem_read_reg    <= mem_read_next;
      mem_write_reg   <= mem_write_next;
      mem_wmask_reg   <= mem_wmask_next;
      mem_address_reg <= mem_address_next;
      mem_wdata_reg   <= mem_wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run, all checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, fls;
  logic        i_read;
  logic [31:0] i_address, i_rdata;
  logic        i_resp;
  logic        d_read, d_write;
  logic [3:0]  d_wmask;
  logic [31:0] d_address, d_wdata, d_rdata;
  logic        d_resp;
  logic        mem_read, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .fls(fls),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is the port owned, by whom, with what payload.
  bit          m_busy, m_side_d, m_cancel, m_last_d, m_zero, m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;

  // Memory responder and requester helpers.
  bit          auto_mem = 1'b1;
  bit          rand_lat = 1'b0;
  int          mem_lat  = 3;
  int          busy_cnt = 0;
  bit          fix_rdata_en = 1'b0;
  logic [31:0] fix_rdata = '0;
  int          i_hold = 0, d_hold = 0;
  byte         log_q[$];            // 0 = fetch response, 1 = data response
  logic [31:0] cap_i_rdata, cap_waddr, cap_wdata;
  logic [3:0]  cap_wmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_side_d = 0; m_cancel = 0; m_last_d = 1; m_zero = 1;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
  endtask

  // One clock cycle: drive memory, check outputs, advance the model.
  task automatic cyc();
    bit exp_i, exp_d, saw_i, saw_d, ireq, dreq;
    if (auto_mem) begin
      if (!rst && (mem_read || mem_write)) begin
        busy_cnt++;
        mem_resp = (busy_cnt == mem_lat);
      end else begin
        busy_cnt = 0;
        mem_resp = 1'b0;
      end
    end
    mem_rdata = fix_rdata_en ? fix_rdata : $urandom;
    #1;
    exp_i = m_busy && !m_side_d && mem_resp && !m_cancel && !fls && !rst;
    exp_d = m_busy && m_side_d && mem_resp && !rst;
    chk("i_resp", i_resp, exp_i);
    chk("d_resp", d_resp, exp_d);
    chk("i_rdata", i_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
    chk("mem_read", mem_read, m_busy && m_rd);
    chk("mem_write", mem_write, m_busy && m_wr);
    chk("mem_address", mem_address, m_addr);
    if ((m_busy && m_side_d) || m_zero) begin
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wmask", mem_wmask, m_wmask);
    end
    saw_i = i_resp;
    saw_d = d_resp;
    if (i_resp) begin log_q.push_back(0); cap_i_rdata = i_rdata; end
    if (d_resp) log_q.push_back(1);
    if (mem_write) begin cap_waddr = mem_address; cap_wdata = mem_wdata; cap_wmask = mem_wmask; end
    if (auto_mem && mem_resp && rand_lat) mem_lat = $urandom_range(1, 4);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      ireq = i_read && !fls;
      dreq = d_read || d_write;
      if (ireq && (!dreq || m_last_d)) begin
        m_busy = 1; m_side_d = 0; m_cancel = 0; m_last_d = 0; m_zero = 0;
        m_rd = 1; m_wr = 0; m_addr = i_address;
      end else if (dreq) begin
        m_busy = 1; m_side_d = 1; m_cancel = 0; m_last_d = 1; m_zero = 0;
        m_rd = d_read && !d_write; m_wr = d_write;
        m_addr = d_address; m_wdata = d_wdata; m_wmask = d_wmask;
      end
    end else if (mem_resp) begin
      m_busy = 0; m_rd = 0; m_wr = 0;
    end else if (!m_side_d && fls) begin
      m_cancel = 1;
    end
    @(negedge clk);
    // Requesters release the request in the cycle after their response.
    if (saw_i) begin i_read = 0; i_hold = 1; end
    if (saw_d) begin d_read = 0; d_write = 0; d_hold = 1; end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((i_read || d_read || d_write || m_busy) && n < limit) begin
      cyc();
      n++;
    end
    if (n >= limit) chk("timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    int i_left, d_left;
    rst = 1; fls = 0; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0; d_wmask = '0;
    mem_rdata = '0; mem_resp = 0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    cyc();
    // Reset state: port idle and cleared.
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    rst = 0;

    // Single fetch.
    log_q.delete();
    fix_rdata_en = 1; fix_rdata = 32'h0050_0093; mem_lat = 3;
    i_read = 1; i_address = 32'h60;
    cyc();
    chk("fetch_mem_read_n1", mem_read, 1);
    wait_done(20);
    fix_rdata_en = 0;
    chk("fetch_resp_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("fetch_resp_side", log_q[0], 0);
    chk("fetch_rdata", cap_i_rdata, 32'h0050_0093);

    // Tie after reset goes to fetch, then the write.
    do_reset();
    log_q.delete(); mem_lat = 2;
    i_read = 1; i_address = 32'h200;
    d_write = 1; d_address = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    wait_done(30);
    chk("tie_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("tie_first", log_q[0], 0);
      chk("tie_second", log_q[1], 1);
    end
    chk("tie_wmask", cap_wmask, 4'b0011);
    chk("tie_waddr", cap_waddr, 32'h100);
    chk("tie_wdata", cap_wdata, 32'hDEAD_BEEF);

    // Round-robin with both sides continuously requesting.
    log_q.delete(); rand_lat = 1;
    i_left = 3; d_left = 3; i_hold = 0; d_hold = 0;
    for (int k = 0; k < 300 && (i_left > 0 || d_left > 0 || i_read || d_read || m_busy); k++) begin
      if (!i_read && i_left > 0) begin
        if (i_hold == 0) begin i_read = 1; i_address = $urandom & 32'hFFFC; i_left--; end
        else i_hold--;
      end
      if (!d_read && d_left > 0) begin
        if (d_hold == 0) begin d_read = 1; d_address = $urandom & 32'hFFFC; d_left--; end
        else d_hold--;
      end
      cyc();
    end
    rand_lat = 0;
    chk("rr_count", log_q.size(), 6);
    for (int k = 0; k < 6 && k < log_q.size(); k++) chk($sformatf("rr_grant%0d", k), log_q[k], k % 2);

    // Flush during a fetch, two cycles before the response.
    log_q.delete(); mem_lat = 4;
    i_read = 1; i_address = 32'h400;
    cyc();
    cyc();
    fls = 1; i_read = 0;
    cyc();
    fls = 0;
    wait_done(20);
    chk("flush_i_no_resp", log_q.size(), 0);
    d_read = 1; d_address = 32'h480;
    cyc();
    chk("flush_idle_after", mem_read, 1);
    wait_done(20);
    chk("flush_then_d", log_q.size(), 1);

    // Flush during a data access is ignored.
    log_q.delete(); mem_lat = 3;
    d_read = 1; d_address = 32'h500;
    cyc();
    fls = 1;
    wait_done(20);
    fls = 0;
    chk("flush_d_resp", log_q.size(), 1);
    if (log_q.size() == 1) chk("flush_d_side", log_q[0], 1);

    // Reset in the middle of a data write.
    log_q.delete(); auto_mem = 0; mem_resp = 0;
    d_write = 1; d_address = 32'h300; d_wdata = 32'h1234_5678; d_wmask = 4'hF;
    cyc();
    cyc();
    chk("rst_mid_write_before", mem_write, 1);
    rst = 1; d_write = 0;
    cyc();
    rst = 0;
    cyc();
    chk("rst_mid_write_after", mem_write, 0);
    mem_resp = 1;
    cyc();
    mem_resp = 0;
    chk("rst_late_resp", log_q.size(), 0);
    auto_mem = 1; mem_lat = 2;
    i_read = 1; i_address = 32'h340; d_read = 1; d_address = 32'h380;
    wait_done(30);
    chk("rst_tie_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("rst_tie_first", log_q[0], 0);

    // Flush in IDLE blocks the fetch for that cycle: data goes first.
    log_q.delete();
    fls = 1; i_read = 1; i_address = 32'h600; d_read = 1; d_address = 32'h700;
    cyc();
    fls = 0;
    wait_done(30);
    chk("idle_fls_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("idle_fls_first", log_q[0], 1);

    // Randomized traffic with random flushes and latencies.
    rand_lat = 1; i_hold = 0; d_hold = 0;
    for (int k = 0; k < 600; k++) begin
      fls = ($urandom_range(0, 7) == 0);
      if (fls && i_read) begin i_read = 0; i_hold = 1; end
      if (!i_read) begin
        if (i_hold > 0) i_hold--;
        else if ($urandom_range(0, 1) == 1) begin i_read = 1; i_address = $urandom & 32'hFFFC; end
      end
      if (!d_read && !d_write) begin
        if (d_hold > 0) d_hold--;
        else if ($urandom_range(0, 1) == 1) begin
          d_address = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
          if ($urandom_range(0, 1) == 1) d_write = 1; else d_read = 1;
        end
      end
      cyc();
    end
    fls = 0;
    wait_done(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
